lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
- Owns the HD44780-style LCD bus (RS, RW, EN, data[7:0]) and is its only driver.
- After reset it waits out the power-up delay, then replays the fixed init sequence: 0x38 four times, then 0x0F, 0x01, 0x06.
- It then serves byte writes from two requesters (requester 0 = operand display, requester 1 = result display) with round-robin arbitration.
- Each byte gets one full EN high/low strobe.

Parameters:
- PWRUP_CYC, 2250000: idle cycles after reset before the first init strobe.
- EN_HIGH_CYC, 125000: cycles EN is held high per byte.
- EN_LOW_CYC, 250000: cycles EN is held low after each strobe, before the next byte may start.
- CW, $clog2(PWRUP_CYC+1): width of the shared delay counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a byte pending
- req0_rs  in  1  requester 0 register select (0 = command, 1 = data)
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte pending
- req1_rs  in  1  requester 1 register select
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- RS  out  1  LCD register select
- RW  out  1  LCD read/write; always 0
- EN  out  1  LCD enable strobe
- data  out  8  LCD data bus
- init_done  out  1  init sequence complete
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high, sampled on the posedge of CLK.
- Reset values: state=PWRUP, cnt=0, init_idx=0, last_grant=1 (so requester 0 wins first), RS=0, RW=0, EN=0, data=0x00, init_done=0, busy=1.
- Reset mid-operation is allowed at any time. EN falls on the reset edge, the whole init sequence reruns, and any in-flight byte is dropped silently.
- States:
  - PWRUP
  - INIT_HI
  - INIT_LO
  - IDLE
  - WR_HI
  - WR_LO
- PWRUP: counts PWRUP_CYC cycles, then goes to INIT_HI with data = INIT_ROM[0] and RS=0.
- INIT_HI: EN=1 for exactly EN_HIGH_CYC cycles, then goes to INIT_LO.
- INIT_LO: EN=0 for exactly EN_LOW_CYC cycles.
  - If init_idx == 6: set init_done=1 and go to IDLE.
  - Otherwise: init_idx++, load INIT_ROM[init_idx] onto data, go to INIT_HI.
- INIT_ROM contents: {0x38, 0x38, 0x38, 0x38, 0x0F, 0x01, 0x06}.
- IDLE: EN=0 and RS/data hold their last values.
- Arbitration (combinational from registered state and the valid inputs):
  - grant0 = IDLE & req0_valid & (~req1_valid | last_grant==1)
  - grant1 = IDLE & req1_valid & (~req0_valid | last_grant==0)
  - reqN_ready = grantN; at most one ready is high in any cycle.
- Acceptance: on a cycle where reqN_valid & reqN_ready:
  - register RS = reqN_rs and data = reqN_data;
  - set last_grant = N;
  - go to WR_HI. EN rises on the following cycle's edge.
- WR_HI / WR_LO: same timing as INIT_HI / INIT_LO. WR_LO returns to IDLE.
- Minimum spacing between two accepted bytes is 1 + EN_HIGH_CYC + EN_LOW_CYC cycles.
- RS and data are stable for the entire HI and LO window of each byte; setup before the EN rise is at least 1 cycle.
- Before init_done both ready outputs are 0. Requesters hold valid/rs/data stable until they see ready.
- Simultaneous valid from both requesters: strict alternation. A requester that holds valid continuously is never starved beyond one byte.
- Counter: cnt resets to 0 on every state change. Terminal condition is cnt == N-1; parameters must be ≥ 1.

Decomposition:
- Shared package lcd_pkg:
  - state enum;
  - INIT_ROM constant array and INIT_LEN = 7;
  - LCD opcode constants (FUNC_SET_8B2L = 0x38, DISP_ON_CUR_BLINK = 0x0F, CLEAR = 0x01, ENTRY_INC = 0x06, ASCII_SPACE = 0x20, ASCII_MINUS = 0x2D, ASCII_PLUS = 0x2B, ASCII_ZERO = 0x30).
- Sub-module lcd_strobe_timer:
  - loads EN_HIGH_CYC then EN_LOW_CYC on start;
  - outputs en and done;
  - is reused by both the init and write paths.

Test Plan (PWRUP_CYC=20, EN_HIGH_CYC=4, EN_LOW_CYC=8):
- Init replay: RST high 2 cycles, then low → EN stays 0 for 20 cycles, then exactly 7 EN pulses, each 4 high / 8 low. data per pulse = 38, 38, 38, 38, 0F, 01, 06; RS=0 and RW=0 throughout. init_done rises together with the entry into IDLE.
- Single write: after init, req0_valid=1, rs=1, data=0x2D → req0_ready high for 1 cycle. On the next edge RS=1, data=0x2D; one EN pulse of 4 cycles follows, then 8 low cycles, then busy=0.
- Contention: req0 and req1 both held valid, bytes 0x31 and 0x2B → accepted order 0, 1, 0, 1. Accept cycles are spaced exactly 13 cycles apart, and no cycle has both readies high.
- Pre-init gating: req1_valid=1 from reset release → req1_ready stays 0 until init_done, then the byte is accepted in the first IDLE cycle.
- Reset mid-strobe: assert RST during WR_HI (EN=1) → EN=0, init_done=0 and busy=1 after that edge. After release the full 20-cycle power-up and 7-byte init sequence repeats.
- Hold check: change req0_data after ready while the strobe is in flight → the bus data is unchanged until the next acceptance.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus sequencer.
// Holds the FSM/strobe enums, the LCD opcodes and the power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_HI,
    ST_INIT_LO,
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO
  } state_e;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_HI,
    PH_LO
  } phase_e;

  localparam logic [7:0] FUNC_SET_8B2L     = 8'h38;
  localparam logic [7:0] DISP_ON_CUR_BLINK = 8'h0F;
  localparam logic [7:0] CLEAR             = 8'h01;
  localparam logic [7:0] ENTRY_INC         = 8'h06;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_MINUS       = 8'h2D;
  localparam logic [7:0] ASCII_PLUS        = 8'h2B;
  localparam logic [7:0] ASCII_ZERO        = 8'h30;

  localparam int INIT_LEN = 7;
  localparam int IDX_W    = $clog2(INIT_LEN);

  // The function-set command is repeated so the controller syncs regardless of its power-up mode.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L,
    DISP_ON_CUR_BLINK, CLEAR, ENTRY_INC
  };

  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (int'(idx) < INIT_LEN) b = INIT_ROM[idx];
    return b;
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// Requester handshakes plus the LCD pin bus owned by the sequencer.
// master = requesters / pin observer side, slave = the sequencer.
interface lcd_bus_sequencer_if;

  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       RS;
  logic       RW;
  logic       EN;
  logic [7:0] data;
  logic       init_done;
  logic       busy;

  modport master (
    output req0_valid, req0_rs, req0_data,
    input  req0_ready,
    output req1_valid, req1_rs, req1_data,
    input  req1_ready,
    input  RS, RW, EN, data, init_done, busy
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    output req0_ready,
    input  req1_valid, req1_rs, req1_data,
    output req1_ready,
    output RS, RW, EN, data, init_done, busy
  );

endinterface

// File: rtl/lcd_strobe_timer.sv
// One EN strobe: EN_HIGH_CYC cycles high then EN_LOW_CYC cycles low, restarted by start_i.
// en_o is registered so it lags the phase by one cycle, giving RS/data setup before EN rises.
module lcd_strobe_timer
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC = 125000,
  parameter int EN_LOW_CYC  = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic en_o,
  output logic hi_done_o,
  output logic done_o
);

  localparam int MAX_CYC = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  phase_e        phase_q, phase_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          en_q;

  assign hi_done_o = (phase_q == PH_HI) && (cnt_q == TW'(EN_HIGH_CYC - 1));
  assign done_o    = (phase_q == PH_LO) && (cnt_q == TW'(EN_LOW_CYC - 1));
  assign en_o      = en_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    if (start_i) begin
      phase_d = PH_HI;
      cnt_d   = '0;
    end else begin
      case (phase_q)
        PH_HI: if (hi_done_o) begin
          phase_d = PH_LO;
          cnt_d   = '0;
        end
        PH_LO: if (done_o) begin
          phase_d = PH_OFF;
          cnt_d   = '0;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= (phase_q == PH_HI);
    end
  end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Sole driver of the LCD bus: power-up wait, init ROM replay, then round-robin
// byte writes from two requesters, one full EN strobe per byte.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC   = 2250000,
  parameter int EN_HIGH_CYC = 125000,
  parameter int EN_LOW_CYC  = 250000,
  parameter int CW          = $clog2(PWRUP_CYC + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  lcd_bus_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             last_grant_q, last_grant_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             init_done_q, init_done_d;

  logic grant0, grant1, busy, strobe_start;
  logic en, hi_done, done;

  lcd_strobe_timer #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .EN_LOW_CYC  (EN_LOW_CYC)
  ) u_strobe (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (strobe_start),
    .en_o      (en),
    .hi_done_o (hi_done),
    .done_o    (done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_PWRUP;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      last_grant_q <= 1'b1;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      last_grant_q <= last_grant_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    last_grant_d = last_grant_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    case (state_q)
      ST_PWRUP: if (cnt_q == CW'(PWRUP_CYC - 1)) begin
        state_d = ST_INIT_HI;
        rs_d    = 1'b0;
        data_d  = init_byte('0);
      end
      ST_INIT_HI: if (hi_done) state_d = ST_INIT_LO;
      ST_INIT_LO: if (done) begin
        if (init_idx_q == IDX_W'(INIT_LEN - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
          data_d     = init_byte(init_idx_q + 1'b1);
          state_d    = ST_INIT_HI;
        end
      end
      ST_IDLE: begin
        if (grant0) begin
          rs_d         = bus.req0_rs;
          data_d       = bus.req0_data;
          last_grant_d = 1'b0;
          state_d      = ST_WR_HI;
        end else if (grant1) begin
          rs_d         = bus.req1_rs;
          data_d       = bus.req1_data;
          last_grant_d = 1'b1;
          state_d      = ST_WR_HI;
        end
      end
      ST_WR_HI: if (hi_done) state_d = ST_WR_LO;
      ST_WR_LO: if (done) state_d = ST_IDLE;
      default:  state_d = ST_PWRUP;
    endcase
    // Only the power-up wait uses this counter; strobe timing lives in the timer.
    cnt_d = (state_q == ST_PWRUP && state_d == ST_PWRUP) ? cnt_q + 1'b1 : '0;
  end

  always_comb begin
    grant0 = (state_q == ST_IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = (state_q == ST_IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    busy   = (state_q != ST_IDLE);
    strobe_start = (state_d != state_q) && (state_d == ST_INIT_HI || state_d == ST_WR_HI);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.RS         = rs_q;
  assign bus.RW         = 1'b0;
  assign bus.EN         = en;
  assign bus.data       = data_q;
  assign bus.init_done  = init_done_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer with shortened timing: init replay, vector writes,
// contention, randomized traffic against a slot-based arbitration model, mid-strobe reset.
module tb_lcd_bus_sequencer;

  localparam int PW       = 20;
  localparam int EH       = 4;
  localparam int EL       = 8;
  localparam int SLOT     = 1 + EH + EL;
  localparam int INIT_END = PW + 7 * (EH + EL);

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         hi;
    int         rise;
    bit         ok;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
  } byte_t;

  typedef struct {
    int         req;
    logic       rs;
    logic [7:0] d;
    logic       exp_rs;
    logic [7:0] exp_d;
  } vec_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   rw_bad = 0;
  int   model_last = 1;

  pulse_t     pulses[$];
  pulse_t     cur;
  bit         en_prev = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] init_tab [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0F, 8'h01, 8'h06};

  lcd_bus_sequencer_if bus();

  lcd_bus_sequencer #(
    .PWRUP_CYC   (PW),
    .EN_HIGH_CYC (EH),
    .EN_LOW_CYC  (EL)
  ) dut (
    .CLK (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: records every EN pulse with its byte, width, rise cycle and setup/hold status.
  always @(negedge clk) begin
    if (bus.RW !== 1'b0) rw_bad++;
    if (bus.EN === 1'b1) begin
      if (!en_prev) begin
        cur.rs   = bus.RS;
        cur.d    = bus.data;
        cur.hi   = 1;
        cur.rise = cyc;
        cur.ok   = (prev_rs === bus.RS) && (prev_d === bus.data);
      end else begin
        cur.hi++;
        if (bus.RS !== cur.rs || bus.data !== cur.d) cur.ok = 1'b0;
      end
    end else if (en_prev) begin
      pulses.push_back(cur);
    end
    en_prev = (bus.EN === 1'b1);
    prev_rs = bus.RS;
    prev_d  = bus.data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic check_pulse(input string nm, input logic rs, input logic [7:0] d, input int rise);
    pulse_t p;
    if (pulses.size() == 0) begin
      chk({nm, "_present"}, 0, 1);
      return;
    end
    p = pulses.pop_front();
    chk({nm, "_data"}, p.d, d);
    chk({nm, "_rs"}, p.rs, rs);
    chk({nm, "_en_width"}, p.hi, EH);
    chk({nm, "_setup_hold"}, p.ok, 1);
    if (rise >= 0) chk({nm, "_rise_cycle"}, p.rise, rise);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask

  // Presents one byte and returns at the negedge after acceptance; acc = cycle ready was high.
  task automatic write_byte(input int r, input logic rs, input logic [7:0] d,
                            output int acc, output bit ok);
    @(negedge clk);
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rs = rs; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rs = rs; bus.req1_data = d;
    end
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic run_init(input bit with_req1);
    int R, early, acc, n;
    @(negedge clk);
    RST = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    R = cyc;
    pulses.delete();
    early = 0;
    if (with_req1) begin
      bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h30;
    end
    while (cyc < R + INIT_END) begin
      #1;
      if (bus.req0_ready || bus.req1_ready || bus.init_done === 1'b1) early++;
      @(negedge clk);
    end
    #1;
    chk("init_gated_before_done", early, 0);
    chk("init_done_at_idle", bus.init_done, 1);
    chk("init_idle_not_busy", bus.busy, 0);
    chk("init_first_idle_accept", bus.req1_ready, with_req1);
    chk("init_pulse_count", pulses.size(), 7);
    for (int k = 0; k < 7; k++)
      check_pulse($sformatf("init%0d", k), 1'b0, init_tab[k], R + PW + 1 + k * (EH + EL));
    if (with_req1) begin
      acc = cyc;
      @(negedge clk);
      bus.req1_valid = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
      check_pulse("preinit_req1", 1'b1, 8'h30, acc + 2);
      model_last = 1;
    end
  endtask

  initial begin
    vec_t  vt [5];
    byte_t pq0[$], pq1[$], expq[$];
    byte_t e;
    int    acc, n, nacc, both, prev, guard, who, w, a, freec;
    int    cwho [4];
    bit    ok, v0, v1;

    vt[0] = '{req: 0, rs: 1'b1, d: 8'h2D, exp_rs: 1'b1, exp_d: 8'h2D};
    vt[1] = '{req: 1, rs: 1'b0, d: 8'h01, exp_rs: 1'b0, exp_d: 8'h01};
    vt[2] = '{req: 0, rs: 1'b1, d: 8'h2B, exp_rs: 1'b1, exp_d: 8'h2B};
    vt[3] = '{req: 0, rs: 1'b0, d: 8'hC0, exp_rs: 1'b0, exp_d: 8'hC0};
    vt[4] = '{req: 1, rs: 1'b1, d: 8'h20, exp_rs: 1'b1, exp_d: 8'h20};

    bus.req0_valid = 1'b1; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_EN", bus.EN, 0);
    chk("rst_RS", bus.RS, 0);
    chk("rst_RW", bus.RW, 0);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_busy", bus.busy, 1);
    chk("rst_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);

    // Init replay with requester 1 waiting from reset release.
    run_init(1'b1);

    // Table vectors, each also a hold check: the requester's data changes mid-strobe.
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      write_byte(vt[i].req, vt[i].rs, vt[i].d, acc, ok);
      chk("vec_accepted", ok, 1);
      if (vt[i].req == 0) bus.req0_data = ~vt[i].d;
      else bus.req1_data = ~vt[i].d;
      chk("vec_bus_data", bus.data, vt[i].exp_d);
      chk("vec_bus_rs", bus.RS, vt[i].exp_rs);
      n = 0;
      while (bus.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("vec_busy_drop_cycle", cyc, acc + SLOT);
      chk("vec_hold_data", bus.data, vt[i].exp_d);
      check_pulse("vec", vt[i].exp_rs, vt[i].exp_d, acc + 2);
      model_last = vt[i].req;
    end

    // Contention: both requesters hold valid continuously.
    wait_idle();
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h31;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h2B;
    nacc = 0; both = 0; prev = -1; guard = 0;
    while (nacc < 4 && guard < 200) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both++;
      else if (bus.req0_ready || bus.req1_ready) begin
        who = bus.req0_ready ? 0 : 1;
        chk("cont_order", who, (model_last == 1) ? 0 : 1);
        if (prev >= 0) chk("cont_spacing", cyc - prev, SLOT);
        prev = cyc;
        model_last = who;
        cwho[nacc] = who;
        nacc++;
      end
      @(negedge clk);
      guard++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("cont_accept_count", nacc, 4);
    chk("cont_both_ready", both, 0);
    wait_idle();
    for (int k = 0; k < nacc; k++)
      check_pulse("cont", 1'b1, (cwho[k] == 0) ? 8'h31 : 8'h2B, -1);

    // Randomized traffic; model: one slot of SLOT cycles per byte, round-robin on collision.
    for (int i = 0; i < 12; i++) begin
      pq0.push_back('{rs: 1'($urandom_range(0, 1)), d: 8'($urandom_range(0, 255))});
      pq1.push_back('{rs: 1'($urandom_range(0, 1)), d: 8'($urandom_range(0, 255))});
    end
    wait_idle();
    freec = cyc;
    v0 = 1'b0; v1 = 1'b0; guard = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || v0 || v1) && guard < 3000) begin
      if (!v0 && pq0.size() > 0 && $urandom_range(0, 2) == 0) v0 = 1'b1;
      if (!v1 && pq1.size() > 0 && $urandom_range(0, 2) == 0) v1 = 1'b1;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      if (v0) begin bus.req0_rs = pq0[0].rs; bus.req0_data = pq0[0].d; end
      if (v1) begin bus.req1_rs = pq1[0].rs; bus.req1_data = pq1[0].d; end
      #1;
      w = -1;
      if (cyc >= freec && (v0 || v1)) w = (v0 && v1) ? ((model_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
      a = -1;
      if (bus.req0_ready && bus.req1_ready) a = 2;
      else if (bus.req0_ready) a = 0;
      else if (bus.req1_ready) a = 1;
      if (w != -1 || a != -1) chk("rand_grant", a, w);
      if (a == 0 && v0) begin
        expq.push_back(pq0.pop_front()); v0 = 1'b0; model_last = 0; freec = cyc + SLOT;
      end else if (a == 1 && v1) begin
        expq.push_back(pq1.pop_front()); v1 = 1'b0; model_last = 1; freec = cyc + SLOT;
      end
      @(negedge clk);
      guard++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rand_finished", guard < 3000, 1);
    wait_idle();
    chk("rand_pulse_count", pulses.size(), expq.size());
    while (expq.size() > 0) begin
      e = expq.pop_front();
      check_pulse("rand", e.rs, e.d, -1);
    end

    // Reset while EN is high, then the full init replays.
    wait_idle();
    write_byte(0, 1'b1, 8'h55, acc, ok);
    n = 0;
    while (bus.EN !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("midrst_en_high", bus.EN, 1);
    RST = 1'b1;
    @(negedge clk);
    chk("midrst_EN", bus.EN, 0);
    chk("midrst_init_done", bus.init_done, 0);
    chk("midrst_busy", bus.busy, 1);
    run_init(1'b0);

    chk("rw_always_zero", rw_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
